// File: rtl/conv_acc_tree_if.sv
// Stream bundle between the multiplier array, the accumulation tree and the result consumer.
// The master drives products and ready; the slave (the tree) returns results and status.
interface conv_acc_tree_if #(
  parameter int WORD_WIDTH = 8,
  parameter int GROUP_SIZE = 9,
  parameter int NUM_GROUPS = 8,
  parameter int ACC_WIDTH  = 20
) ();
  logic [WORD_WIDTH*GROUP_SIZE*NUM_GROUPS-1:0] i_products;
  logic                                        i_valid;
  logic                                        i_last;
  logic [ACC_WIDTH*NUM_GROUPS-1:0]             o_sums;
  logic                                        o_valid;
  logic                                        i_ready;
  logic                                        o_overrun;
  logic                                        o_busy;

  modport master (
    output i_products, i_valid, i_last, i_ready,
    input  o_sums, o_valid, o_overrun, o_busy
  );

  modport slave (
    input  i_products, i_valid, i_last, i_ready,
    output o_sums, o_valid, o_overrun, o_busy
  );
endinterface

// File: rtl/conv_acc_tree.sv
// Registered per-lane adder tree, multi-pass accumulator and 2-entry result buffer
// for the Conv2D3x3 datapath; the input side never stalls.
module conv_acc_tree #(
  parameter int WORD_WIDTH = 8,
  parameter int GROUP_SIZE = 9,
  parameter int NUM_GROUPS = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  conv_acc_tree_if.slave bus
);
  localparam int TREE_STAGES = $clog2(GROUP_SIZE);
  localparam int SUM_W       = WORD_WIDTH + TREE_STAGES;
  localparam int HALF        = (GROUP_SIZE + 1) / 2;
  localparam int W2          = 2 * HALF;
  localparam int RES_W       = ACC_WIDTH * NUM_GROUPS;

  localparam logic [0:0] ACC_EMPTY = 1'b0;
  localparam logic [0:0] ACC_RUN   = 1'b1;

  if (ACC_WIDTH < WORD_WIDTH + TREE_STAGES) begin : gWidthCheck
    $error("conv_acc_tree: ACC_WIDTH too small for a lossless group sum");
  end
  if (GROUP_SIZE < 2) begin : gGroupCheck
    $error("conv_acc_tree: GROUP_SIZE must be at least 2");
  end

  // Every level is padded to W2 slots that stay zero beyond the live node
  // count, so an odd leftover simply adds zero and passes through its level.
  logic [SUM_W-1:0] leaf       [NUM_GROUPS][W2];
  logic [SUM_W-1:0] treeNode_q [NUM_GROUPS][TREE_STAGES][W2];
  logic [TREE_STAGES-1:0] validPipe_q;
  logic [TREE_STAGES-1:0] lastPipe_q;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : gLeafGroup
    for (genvar k = 0; k < W2; k++) begin : gLeaf
      if (k < GROUP_SIZE) begin : gTerm
        assign leaf[g][k] = SUM_W'(bus.i_products[WORD_WIDTH*(g*GROUP_SIZE+k) +: WORD_WIDTH]);
      end else begin : gZero
        assign leaf[g][k] = '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : gGroup
    for (genvar l = 0; l < TREE_STAGES; l++) begin : gLevel
      for (genvar j = 0; j < W2; j++) begin : gNode
        if (j < HALF) begin : gAdd
          logic [SUM_W-1:0] opA;
          logic [SUM_W-1:0] opB;
          if (l == 0) begin : gFromLeaf
            assign opA = leaf[g][2*j];
            assign opB = leaf[g][2*j+1];
          end else begin : gFromNode
            assign opA = treeNode_q[g][l-1][2*j];
            assign opB = treeNode_q[g][l-1][2*j+1];
          end
          always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) treeNode_q[g][l][j] <= '0;
            else          treeNode_q[g][l][j] <= opA + opB;
          end
        end else begin : gPad
          always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) treeNode_q[g][l][j] <= '0;
            else          treeNode_q[g][l][j] <= '0;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      validPipe_q <= '0;
      lastPipe_q  <= '0;
    end else begin
      validPipe_q[0] <= bus.i_valid;
      lastPipe_q[0]  <= bus.i_valid & bus.i_last;
      for (int s = 1; s < TREE_STAGES; s++) begin
        validPipe_q[s] <= validPipe_q[s-1];
        lastPipe_q[s]  <= lastPipe_q[s-1];
      end
    end
  end

  logic                 treeValid;
  logic                 treeLast;
  logic [0:0]           state_q;
  logic [0:0]           state_d;
  logic [ACC_WIDTH-1:0] accSum_q    [NUM_GROUPS];
  logic [ACC_WIDTH-1:0] accSum_d    [NUM_GROUPS];
  logic [ACC_WIDTH-1:0] laneResult  [NUM_GROUPS];
  logic [RES_W-1:0]     resultWord;
  logic                 emit;

  assign treeValid = validPipe_q[TREE_STAGES-1];
  assign treeLast  = lastPipe_q[TREE_STAGES-1];

  // An empty accumulator contributes zero, so both states share one adder.
  always_comb begin
    state_d    = state_q;
    emit       = 1'b0;
    resultWord = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      laneResult[g] = ((state_q == ACC_RUN) ? accSum_q[g] : '0)
                      + ACC_WIDTH'(treeNode_q[g][TREE_STAGES-1][0]);
      accSum_d[g]   = accSum_q[g];
      resultWord[ACC_WIDTH*g +: ACC_WIDTH] = laneResult[g];
    end
    if (treeValid) begin
      if (treeLast) begin
        emit    = 1'b1;
        state_d = ACC_EMPTY;
      end else begin
        state_d = ACC_RUN;
        for (int g = 0; g < NUM_GROUPS; g++) accSum_d[g] = laneResult[g];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ACC_EMPTY;
      for (int g = 0; g < NUM_GROUPS; g++) accSum_q[g] <= '0;
    end else begin
      state_q <= state_d;
      for (int g = 0; g < NUM_GROUPS; g++) accSum_q[g] <= accSum_d[g];
    end
  end

  logic [RES_W-1:0] fifoMem_q [2];
  logic             wrPtr_q;
  logic             rdPtr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             overrun_q;
  logic             rdEn;
  logic             wrEn;
  logic             drop;

  // A read at full frees the head slot, which is exactly where the write lands.
  always_comb begin
    rdEn = (count_q != 2'd0) && bus.i_ready;
    wrEn = emit && ((count_q != 2'd2) || rdEn);
    drop = emit && !wrEn;
    case ({wrEn, rdEn})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifoMem_q[0] <= '0;
      fifoMem_q[1] <= '0;
      wrPtr_q      <= 1'b0;
      rdPtr_q      <= 1'b0;
      count_q      <= 2'd0;
      overrun_q    <= 1'b0;
    end else begin
      if (wrEn) fifoMem_q[wrPtr_q] <= resultWord;
      wrPtr_q   <= wrPtr_q ^ wrEn;
      rdPtr_q   <= rdPtr_q ^ rdEn;
      count_q   <= count_d;
      overrun_q <= overrun_q | drop;
    end
  end

  assign bus.o_sums    = fifoMem_q[rdPtr_q];
  assign bus.o_valid   = (count_q != 2'd0);
  assign bus.o_overrun = overrun_q;
  assign bus.o_busy    = (state_q == ACC_RUN) || (|validPipe_q);
endmodule

// File: tb/tb_conv_acc_tree.sv
// Directed bench for conv_acc_tree: single/multi pass sums, wrap, backpressure,
// full-buffer read/write and mid-accumulation reset, with hand-computed results.
module tb_conv_acc_tree;
  localparam int WW = 8;
  localparam int GS = 9;
  localparam int NG = 8;
  localparam int AW = 20;

  logic i_clk;
  logic i_rst_n;
  int   checkCount;
  int   errorCount;
  int   expWide;

  conv_acc_tree_if #(.WORD_WIDTH(WW), .GROUP_SIZE(GS), .NUM_GROUPS(NG), .ACC_WIDTH(AW)) bus ();

  conv_acc_tree #(.WORD_WIDTH(WW), .GROUP_SIZE(GS), .NUM_GROUPS(NG), .ACC_WIDTH(AW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Every term gets value, or value*(lane+1) when laneScaled is set.
  task automatic applyStimulus(input int value, input bit laneScaled, input bit valid, input bit last);
    logic [WW*GS*NG-1:0] words;
    for (int k = 0; k < GS*NG; k++) begin
      words[WW*k +: WW] = laneScaled ? WW'(value * (k / GS + 1)) : WW'(value);
    end
    bus.i_products = words;
    bus.i_valid    = valid;
    bus.i_last     = last;
  endtask

  function automatic logic [31:0] lane(input int g);
    return 32'(bus.o_sums[AW*g +: AW]);
  endfunction

  initial begin
    checkCount = 0;
    errorCount = 0;
    bus.i_ready = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    i_rst_n = 1'b0;
    #2;
    checkOutput("rst_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("rst_overrun", 32'(bus.o_overrun), 32'd0);
    checkOutput("rst_sums", 32'(bus.o_sums == '0), 32'd1);
    tick();
    tick();
    i_rst_n = 1'b1;

    // Single pass of ones: result exactly five cycles later.
    applyStimulus(1, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("single_busy", 32'(bus.o_busy), 32'd1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      checkOutput("single_early", 32'(bus.o_valid), 32'd0);
    end
    tick();
    checkOutput("single_valid", 32'(bus.o_valid), 32'd1);
    checkOutput("single_idle", 32'(bus.o_busy), 32'd0);
    for (int g = 0; g < NG; g++) checkOutput("single_lane", lane(g), 32'd9);
    tick();
    checkOutput("single_drained", 32'(bus.o_valid), 32'd0);

    // Three lane-distinct passes, last on the third.
    applyStimulus(1, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1, 1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput("multi_none", 32'(bus.o_valid), 32'd0);
    for (int c = 4; c <= 6; c++) begin
      tick();
      checkOutput("multi_none", 32'(bus.o_valid), 32'd0);
    end
    tick();
    checkOutput("multi_valid", 32'(bus.o_valid), 32'd1);
    for (int g = 0; g < NG; g++) checkOutput("multi_lane", lane(g), 32'(27 * (g + 1)));
    tick();
    checkOutput("multi_once", 32'(bus.o_valid), 32'd0);

    // 500 passes of 255 exceed 2^20 and wrap; then 457 passes wrap to 239.
    for (int p = 0; p < 500; p++) begin
      applyStimulus(255, 1'b0, 1'b1, p == 499);
      tick();
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    expWide = (500 * 9 * 255) % (1 << AW);
    checkOutput("max500_valid", 32'(bus.o_valid), 32'd1);
    checkOutput("max500_lane0", lane(0), 32'(expWide));
    checkOutput("max500_lane7", lane(7), 32'(expWide));
    tick();
    for (int p = 0; p < 457; p++) begin
      applyStimulus(255, 1'b0, 1'b1, p == 456);
      tick();
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("wrap_valid", 32'(bus.o_valid), 32'd1);
    checkOutput("wrap_lane0", lane(0), 32'd239);
    checkOutput("wrap_lane7", lane(7), 32'd239);
    tick();

    // Backpressure: third result dropped, buffer drains in order.
    bus.i_ready = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      applyStimulus(v, 1'b0, 1'b1, 1'b1);
      tick();
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("bp_overrun", 32'(bus.o_overrun), 32'd1);
    checkOutput("bp_valid", 32'(bus.o_valid), 32'd1);
    checkOutput("bp_head0", lane(0), 32'd9);
    checkOutput("bp_head7", lane(7), 32'd9);
    bus.i_ready = 1'b1;
    tick();
    checkOutput("bp_second", lane(0), 32'd18);
    checkOutput("bp_second_valid", 32'(bus.o_valid), 32'd1);
    tick();
    checkOutput("bp_empty", 32'(bus.o_valid), 32'd0);
    checkOutput("bp_sticky", 32'(bus.o_overrun), 32'd1);

    // Reset during a two-pass partial; the partial must not survive.
    applyStimulus(1, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    checkOutput("partial_busy", 32'(bus.o_busy), 32'd1);
    checkOutput("partial_quiet", 32'(bus.o_valid), 32'd0);
    i_rst_n = 1'b0;
    #2;
    checkOutput("mrst_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("mrst_overrun", 32'(bus.o_overrun), 32'd0);
    checkOutput("mrst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("mrst_sums", 32'(bus.o_sums == '0), 32'd1);
    tick();
    i_rst_n = 1'b1;
    applyStimulus(1, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("mrst_result_valid", 32'(bus.o_valid), 32'd1);
    checkOutput("mrst_result", lane(3), 32'd9);
    tick();

    // Full buffer receives a result in the very cycle the head is read.
    bus.i_ready = 1'b0;
    applyStimulus(1, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(2, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    repeat (8) tick();
    checkOutput("full_valid", 32'(bus.o_valid), 32'd1);
    checkOutput("full_head", lane(0), 32'd9);
    applyStimulus(3, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    checkOutput("rw_overrun", 32'(bus.o_overrun), 32'd0);
    checkOutput("rw_head", lane(0), 32'd18);
    tick();
    checkOutput("rw_hold", lane(5), 32'd18);
    checkOutput("rw_hold_valid", 32'(bus.o_valid), 32'd1);
    bus.i_ready = 1'b1;
    tick();
    checkOutput("rw_third", lane(0), 32'd27);
    tick();
    checkOutput("rw_empty", 32'(bus.o_valid), 32'd0);
    checkOutput("rw_no_overrun", 32'(bus.o_overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
